// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding.
// The receiver side of the link imports the same frame levels.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

    // Width of a 0..cpb-1 counter, never below one bit.
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// uart_baud_tick: per-bit cycle counter for the UART transmitter.
// Ports: clk, reset (sync, high), clear (hold count at 0),
//   bit_end (count == CLKS_PER_BIT-1),
//   pre_end (the next cycle will be a bit_end cycle).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic pre_end
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  =
        CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

    // Lets the FSM register outputs that must be high exactly
    // in the last cycle of a bit period.
    assign pre_end = (CLKS_PER_BIT == 1) ? 1'b1
                   : (!clear && !bit_end && cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART frame transmitter: start, 8 data bits LSB first, [parity], stop.
// Ports: clk, reset (sync, high), tx_data/tx_valid/tx_ready handshake,
//   signal (registered serial line, idles high),
//   frame_done (pulse in last stop-bit cycle).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       signal,
    output logic       frame_done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_e  state;
    logic [7:0] shreg;
    logic [BW-1:0] bit_cnt;
    logic       bit_end;
    logic       pre_end;
    logic       accept;
    logic       clear;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif

    assign accept = tx_valid && tx_ready;
    assign clear  = (state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .bit_end(bit_end),
        .pre_end(pre_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            signal     <= UART_IDLE_LVL;
            tx_ready   <= 1'b1;
            frame_done <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= START;
                        signal   <= UART_START_LVL;
                        shreg    <= tx_data;
                        tx_ready <= 1'b0;
                    end else begin
                        signal   <= UART_IDLE_LVL;
                        tx_ready <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        signal  <= shreg[0];
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        par     <= ^shreg;
`endif
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            signal <= par;
`else
                            state      <= STOP;
                            signal     <= UART_STOP_LVL;
                            tx_ready   <= pre_end;
                            frame_done <= pre_end;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            signal  <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state      <= STOP;
                        signal     <= UART_STOP_LVL;
                        tx_ready   <= pre_end;
                        frame_done <= pre_end;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (accept) begin
                            // Back-to-back: next start bit follows
                            // the stop bit with no idle gap.
                            state    <= START;
                            signal   <= UART_START_LVL;
                            shreg    <= tx_data;
                            tx_ready <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            signal   <= UART_IDLE_LVL;
                            tx_ready <= 1'b1;
                        end
                    end else begin
                        tx_ready   <= pre_end;
                        frame_done <= pre_end;
                    end
                end
                default: begin
                    state    <= IDLE;
                    signal   <= UART_IDLE_LVL;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLKS_PER_BIT 1 and 4 instances).
// Expected line levels come from a frame model built from the byte.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data1;
    logic       valid1;
    logic       ready1;
    logic       sig1;
    logic       fd1;
    logic [7:0] data4;
    logic       valid4;
    logic       ready4;
    logic       sig4;
    logic       fd4;

    int checks;
    int failures;

    logic       exp_bits[NB];
    logic       line_s[NB];
    logic [7:0] sbuf[4];

    uart_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (data1),
        .tx_valid  (valid1),
        .tx_ready  (ready1),
        .signal    (sig1),
        .frame_done(fd1)
    );

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (data4),
        .tx_valid  (valid4),
        .tx_ready  (ready4),
        .signal    (sig4),
        .frame_done(fd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame model: start 0, data LSB first, optional even parity, stop 1.
    task automatic build_frame(input logic [7:0] b);
        logic p;
        p = 1'b0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_bits[1 + i] = b[i];
            p = p ^ b[i];
        end
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = p;
`endif
        exp_bits[NB - 1] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid1 = 1'b0;
        valid4 = 1'b0;
        data1 = 8'h00;
        data4 = 8'h00;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({sig1, ready1, fd1} !== 3'b110) begin
                failures++;
                $display("FAIL reset_idle%0d got=%b%b%b want=110",
                         i, sig1, ready1, fd1);
            end
            checks++;
            if ({sig4, ready4, fd4} !== 3'b110) begin
                failures++;
                $display("FAIL reset_idle4_%0d got=%b%b%b want=110",
                         i, sig4, ready4, fd4);
            end
        end
    endtask

    // One frame on dut1 with junk on tx_valid/tx_data mid-frame.
    task automatic test_frame(input logic [7:0] b, input int gap);
        logic [7:0] got;
        logic       e_last;
        build_frame(b);
        got = 8'h00;
        checks++;
        if (ready1 !== 1'b1) begin
            failures++;
            $display("FAIL ready_pre_%h got=%b want=1", b, ready1);
        end
        valid1 = 1'b1;
        data1 = b;
        step();
        for (int k = 0; k < NB; k++) begin
            e_last = (k == NB - 1);
            line_s[k] = sig1;
            checks++;
            if (sig1 !== exp_bits[k]) begin
                failures++;
                $display("FAIL line_%h_bit%0d got=%b want=%b",
                         b, k, sig1, exp_bits[k]);
            end
            checks++;
            if (fd1 !== e_last || ready1 !== e_last) begin
                failures++;
                $display("FAIL fd_rdy_%h_bit%0d got=%b%b want=%b%b",
                         b, k, fd1, ready1, e_last, e_last);
            end
            if (k >= 1 && k <= 8) got[k - 1] = sig1;
            if (k < NB - 1) begin
                valid1 = 1'($urandom);
                data1 = 8'($urandom);
            end else begin
                valid1 = 1'b0;
            end
            step();
        end
        checks++;
        if (got !== b) begin
            failures++;
            $display("FAIL rx_byte got=%h want=%h", got, b);
        end
        for (int i = 0; i <= gap; i++) begin
            checks++;
            if ({sig1, ready1, fd1} !== 3'b110) begin
                failures++;
                $display("FAIL post_idle_%h got=%b%b%b want=110",
                         b, sig1, ready1, fd1);
            end
            if (i < gap) step();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            test_frame(8'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    // tx_valid held high across sbuf[0..n-1]; no idle gap expected.
    task automatic test_stream(input int n);
        logic       e_last;
        logic [7:0] got;
        valid1 = 1'b1;
        data1 = sbuf[0];
        step();
        for (int j = 0; j < n; j++) begin
            build_frame(sbuf[j]);
            got = 8'h00;
            for (int k = 0; k < NB; k++) begin
                e_last = (k == NB - 1);
                checks++;
                if (sig1 !== exp_bits[k]) begin
                    failures++;
                    $display("FAIL b2b_f%0d_bit%0d got=%b want=%b",
                             j, k, sig1, exp_bits[k]);
                end
                checks++;
                if (fd1 !== e_last || ready1 !== e_last) begin
                    failures++;
                    $display("FAIL b2b_fd_f%0d_bit%0d got=%b%b want=%b%b",
                             j, k, fd1, ready1, e_last, e_last);
                end
                if (k >= 1 && k <= 8) got[k - 1] = sig1;
                if (e_last) begin
                    if (j + 1 < n) data1 = sbuf[j + 1];
                    else valid1 = 1'b0;
                end
                step();
            end
            checks++;
            if (got !== sbuf[j]) begin
                failures++;
                $display("FAIL b2b_rx_f%0d got=%h want=%h",
                         j, got, sbuf[j]);
            end
        end
        checks++;
        if ({sig1, ready1, fd1} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_idle got=%b%b%b want=110",
                     sig1, ready1, fd1);
        end
    endtask

    task automatic test_back_to_back();
        sbuf[0] = 8'hFF;
        sbuf[1] = 8'h00;
        test_stream(2);
        for (int i = 0; i < 4; i++) sbuf[i] = 8'($urandom);
        test_stream(4);
    endtask

    task automatic test_reset_mid();
        build_frame(8'hA5);
        valid1 = 1'b1;
        data1 = 8'hA5;
        step();
        valid1 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if (sig1 !== exp_bits[k]) begin
                failures++;
                $display("FAIL rmid_bit%0d got=%b want=%b",
                         k, sig1, exp_bits[k]);
            end
            if (k < 5) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({sig1, ready1, fd1} !== 3'b110) begin
            failures++;
            $display("FAIL rmid_after got=%b%b%b want=110",
                     sig1, ready1, fd1);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (sig1 !== 1'b1 || fd1 !== 1'b0) begin
                failures++;
                $display("FAIL rmid_quiet%0d got=%b%b want=10",
                         i, sig1, fd1);
            end
        end
        // Handshake coinciding with reset: byte must be dropped.
        valid1 = 1'b1;
        data1 = 8'h3C;
        reset = 1'b1;
        step();
        valid1 = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({sig1, ready1, fd1} !== 3'b110) begin
                failures++;
                $display("FAIL rwin%0d got=%b%b%b want=110",
                         i, sig1, ready1, fd1);
            end
            step();
        end
    endtask

    task automatic test_cpb4(input logic [7:0] b);
        logic e_last;
        build_frame(b);
        valid4 = 1'b1;
        data4 = b;
        step();
        valid4 = 1'b0;
        for (int c = 0; c < NB * 4; c++) begin
            e_last = (c == NB * 4 - 1);
            checks++;
            if (sig4 !== exp_bits[c / 4]) begin
                failures++;
                $display("FAIL cpb4_%h_c%0d got=%b want=%b",
                         b, c, sig4, exp_bits[c / 4]);
            end
            checks++;
            if (fd4 !== e_last || ready4 !== e_last) begin
                failures++;
                $display("FAIL cpb4_fd_%h_c%0d got=%b%b want=%b%b",
                         b, c, fd4, ready4, e_last, e_last);
            end
            data4 = 8'($urandom);
            step();
        end
        checks++;
        if ({sig4, ready4, fd4} !== 3'b110) begin
            failures++;
            $display("FAIL cpb4_idle got=%b%b%b want=110",
                     sig4, ready4, fd4);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        test_frame(8'h07, 2);
        checks++;
        if (line_s[9] !== 1'b1 || line_s[10] !== 1'b1) begin
            failures++;
            $display("FAIL parity_07 got=%b%b want=11",
                     line_s[9], line_s[10]);
        end
        test_frame(8'h03, 0);
        checks++;
        if (line_s[9] !== 1'b0) begin
            failures++;
            $display("FAIL parity_03 got=%b want=0", line_s[9]);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_frame(8'h55, 1);
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_cpb4(8'h01);
        test_cpb4(8'($urandom));
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
